surf_simplified_box_sum: RTL and testbench



---
 rtl/surf_simplified_box_sum.sv | 151 +++++++++++++++
 tb/tb_surf_simplified_box_sum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/surf_simplified_box_sum.sv
// Serial box-filter corner accumulator (D - C - B + A) with 16-bit signed saturation,
// feeding the SURF Hessian weighting multiplier over a registered valid/ready output.
module surf_simplified_box_sum #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int WT_WIDTH  = 11
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  corner_data,
    input  logic [WT_WIDTH-1:0]  corner_wt,
    input  logic                 corner_valid,
    output logic                 corner_ready,
    input  logic                 abort,
    output logic [OUT_WIDTH-1:0] sum_dout,
    output logic [WT_WIDTH-1:0]  wt_dout,
    output logic                 sat_flag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int ACC_W = IN_WIDTH + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_D,
        S_C,
        S_B,
        S_A,
        S_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WT_WIDTH-1:0]    wt_reg_q, wt_reg_d;
    logic [OUT_WIDTH-1:0]   sum_dout_q, sum_dout_d;
    logic [WT_WIDTH-1:0]    wt_dout_q, wt_dout_d;
    logic                   sat_flag_q, sat_flag_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [ACC_W-1:0] corner_ext;
    logic signed [ACC_W-1:0] sum_full;
    logic [OUT_WIDTH-1:0]    sum_sat;
    logic                    sum_clamped;
    logic                    accept;

    assign corner_ready = (state_q != S_OUT) && !ap_rst;
    assign accept       = corner_valid && corner_ready;
    assign corner_ext   = {2'b00, corner_data};
    assign sum_full     = acc_q + corner_ext;

    // Two guard bits on the accumulator mean the final sum never wraps, so a plain compare suffices.
    always_comb begin
        sum_sat     = sum_full[OUT_WIDTH-1:0];
        sum_clamped = 1'b0;
        if (sum_full > SAT_MAX) begin
            sum_sat     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sum_clamped = 1'b1;
        end else if (sum_full < SAT_MIN) begin
            sum_sat     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sum_clamped = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        wt_reg_d    = wt_reg_q;
        sum_dout_d  = sum_dout_q;
        wt_dout_d   = wt_dout_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = out_valid_q;

        if (abort) begin
            state_d     = S_D;
            acc_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_D: begin
                    if (accept) begin
                        acc_d    = corner_ext;
                        wt_reg_d = corner_wt;
                        state_d  = S_C;
                    end
                end
                S_C: begin
                    if (accept) begin
                        acc_d   = acc_q - corner_ext;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (accept) begin
                        acc_d   = acc_q - corner_ext;
                        state_d = S_A;
                    end
                end
                S_A: begin
                    if (accept) begin
                        sum_dout_d  = sum_sat;
                        wt_dout_d   = wt_reg_q;
                        sat_flag_d  = sum_clamped;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_D;
                    end
                end
                default: begin
                    state_d     = S_D;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= S_D;
            acc_q       <= '0;
            wt_reg_q    <= '0;
            sum_dout_q  <= '0;
            wt_dout_q   <= '0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            wt_reg_q    <= wt_reg_d;
            sum_dout_q  <= sum_dout_d;
            wt_dout_q   <= wt_dout_d;
            sat_flag_q  <= sat_flag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum_dout  = sum_dout_q;
    assign wt_dout   = wt_dout_q;
    assign sat_flag  = sat_flag_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_surf_simplified_box_sum.sv
// Directed self-checking bench for surf_simplified_box_sum: corner sequences with
// hand-computed box sums, saturation, backpressure, abort and async reset.
module tb_surf_simplified_box_sum;

    logic        ap_clk;
    logic        ap_rst;
    logic [31:0] corner_data;
    logic [10:0] corner_wt;
    logic        corner_valid;
    logic        corner_ready;
    logic        abort;
    logic [15:0] sum_dout;
    logic [10:0] wt_dout;
    logic        sat_flag;
    logic        out_valid;
    logic        out_ready;

    int testCount;
    int failCount;
    int cycleCount;
    int lastOutCycle;

    surf_simplified_box_sum #(
        .IN_WIDTH (32),
        .OUT_WIDTH(16),
        .WT_WIDTH (11)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .corner_data (corner_data),
        .corner_wt   (corner_wt),
        .corner_valid(corner_valid),
        .corner_ready(corner_ready),
        .abort       (abort),
        .sum_dout    (sum_dout),
        .wt_dout     (wt_dout),
        .sat_flag    (sat_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Step past the next rising edge; inputs set afterwards apply to the following edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [10:0] wt);
        corner_data  = data;
        corner_wt    = wt;
        corner_valid = 1'b1;
        checkOutput("ready_before_accept", 64'(corner_ready), 64'd1);
        tick();
        corner_valid = 1'b0;
        corner_data  = '0;
        corner_wt    = '0;
    endtask

    task automatic sendBox(input logic [31:0] d, input logic [31:0] c, input logic [31:0] b,
                           input logic [31:0] a, input logic [10:0] wt);
        applyStimulus(d, wt);
        applyStimulus(c, 11'd0);
        applyStimulus(b, 11'd0);
        applyStimulus(a, 11'd0);
    endtask

    task automatic expectBox(input string tag, input logic [15:0] sum, input logic [10:0] wt,
                             input logic sat);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_sum"}, 64'(sum_dout), 64'(sum));
        checkOutput({tag, "_wt"}, 64'(wt_dout), 64'(wt));
        checkOutput({tag, "_sat"}, 64'(sat_flag), 64'(sat));
        checkOutput({tag, "_ready_low"}, 64'(corner_ready), 64'd0);
    endtask

    initial begin
        testCount    = 0;
        failCount    = 0;
        cycleCount   = 0;
        lastOutCycle = 0;
        ap_rst       = 1'b1;
        corner_data  = '0;
        corner_wt    = '0;
        corner_valid = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b1;

        #3;
        checkOutput("rst_ready", 64'(corner_ready), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_sum", 64'(sum_dout), 64'd0);
        checkOutput("rst_wt", 64'(wt_dout), 64'd0);
        checkOutput("rst_sat", 64'(sat_flag), 64'd0);
        tick();
        tick();
        ap_rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 64'(corner_ready), 64'd1);

        // Basic box: 1000 - 300 - 200 + 50 = 550, valid exactly one cycle.
        sendBox(32'd1000, 32'd300, 32'd200, 32'd50, 11'd81);
        expectBox("basic", 16'd550, 11'd81, 1'b0);
        tick();
        checkOutput("basic_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("basic_ready_back", 64'(corner_ready), 64'd1);

        sendBox(32'd100000, 32'd0, 32'd0, 32'd0, 11'd3);
        expectBox("sat_pos", 16'h7fff, 11'd3, 1'b1);
        tick();
        sendBox(32'd0, 32'd40000, 32'd0, 32'd0, 11'd4);
        expectBox("sat_neg", 16'h8000, 11'd4, 1'b1);
        tick();
        sendBox(32'd40000, 32'd39999, 32'd0, 32'd0, 11'd2047);
        expectBox("near_cancel", 16'd1, 11'd2047, 1'b0);
        tick();

        // Gapped input between C and B, then held backpressure.
        applyStimulus(32'd1000, 11'd81);
        applyStimulus(32'd300, 11'd0);
        tick();
        tick();
        out_ready = 1'b0;
        applyStimulus(32'd200, 11'd0);
        applyStimulus(32'd50, 11'd0);
        for (int k = 0; k < 3; k++) begin
            expectBox("backpressure", 16'd550, 11'd81, 1'b0);
            tick();
        end
        expectBox("bp_final", 16'd550, 11'd81, 1'b0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_valid_drop", 64'(out_valid), 64'd0);
        checkOutput("bp_ready_back", 64'(corner_ready), 64'd1);

        // Abort with a corner present: B=7 must be discarded.
        applyStimulus(32'd500, 11'd9);
        applyStimulus(32'd100, 11'd0);
        corner_data  = 32'd7;
        corner_valid = 1'b1;
        abort        = 1'b1;
        checkOutput("abort_ready_high", 64'(corner_ready), 64'd1);
        tick();
        abort        = 1'b0;
        corner_valid = 1'b0;
        corner_data  = '0;
        checkOutput("abort_no_valid", 64'(out_valid), 64'd0);
        sendBox(32'd10, 32'd2, 32'd3, 32'd1, 11'd5);
        expectBox("after_abort", 16'd6, 11'd5, 1'b0);
        tick();

        // Abort in S_OUT beats out_ready.
        sendBox(32'd20, 32'd5, 32'd5, 32'd0, 11'd1);
        expectBox("out_abort", 16'd10, 11'd1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("out_abort_valid", 64'(out_valid), 64'd0);
        checkOutput("out_abort_ready", 64'(corner_ready), 64'd1);

        // Async reset between B and A, away from any clock edge.
        applyStimulus(32'd1000, 11'd81);
        applyStimulus(32'd300, 11'd0);
        applyStimulus(32'd200, 11'd0);
        #2;
        ap_rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_sum", 64'(sum_dout), 64'd0);
        checkOutput("arst_wt", 64'(wt_dout), 64'd0);
        checkOutput("arst_sat", 64'(sat_flag), 64'd0);
        checkOutput("arst_ready", 64'(corner_ready), 64'd0);
        tick();
        ap_rst = 1'b0;
        #1;
        sendBox(32'd1000, 32'd300, 32'd200, 32'd50, 11'd81);
        expectBox("post_arst", 16'd550, 11'd81, 1'b0);
        tick();

        // Back-to-back boxes at the minimum five-cycle period.
        sendBox(32'd1000, 32'd300, 32'd200, 32'd50, 11'd81);
        expectBox("b2b0", 16'd550, 11'd81, 1'b0);
        lastOutCycle = cycleCount;
        tick();
        sendBox(32'd10, 32'd2, 32'd3, 32'd1, 11'd5);
        expectBox("b2b1", 16'd6, 11'd5, 1'b0);
        checkOutput("b2b1_period", 64'(cycleCount - lastOutCycle), 64'd5);
        lastOutCycle = cycleCount;
        tick();
        sendBox(32'd70000, 32'd0, 32'd0, 32'd0, 11'd7);
        expectBox("b2b2", 16'h7fff, 11'd7, 1'b1);
        checkOutput("b2b2_period", 64'(cycleCount - lastOutCycle), 64'd5);
        tick();
        checkOutput("b2b_end_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
